pkheader_fetch: RTL and testbench

PKHEADER_FETCH -- requirements
Module: pkheader_fetch

---
 rtl/pkheader_fetch_pkg.sv | 17 +
 rtl/pkheader_fetch_rr_arb.sv | 34 +++
 rtl/pkheader_fetch.sv | 130 +++++++++++++
 tb/tb_pkheader_fetch.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkheader_fetch_pkg.sv
// Shared definitions for the packet header fetcher: FSM encoding, header
// length and field byte offsets within the header.
package pkheader_fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned HDR_LEN  = 12;
  localparam int unsigned MAC_OFS  = 0;
  localparam int unsigned IP_OFS   = 6;
  localparam int unsigned PORT_OFS = 10;

endpackage

// File: rtl/pkheader_fetch_rr_arb.sv
// Two-requester round-robin arbiter; the pointer names the requester that
// wins a tie and flips to the other side whenever a grant is taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant_id = (req == 2'b11) ? ptr_q : req[1];
    grant    = 2'b00;
    if (req != 2'b00) begin
      grant = grant_id ? 2'b10 : 2'b01;
    end
    ptr_d = ptr_q;
    if (advance && (req != 2'b00)) begin
      ptr_d = ~grant_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/pkheader_fetch.sv
// Fetches a 12-byte header from a synchronous RAM on behalf of one of two
// requesters and publishes the decoded MAC/IP/port fields atomically.
module pkheader_fetch
  import pkheader_fetch_pkg::*;
#(
  parameter int unsigned aw       = 5,
  parameter int unsigned dw       = 8,
  parameter int unsigned HDR_BASE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  output logic [1:0]    ack,
  output logic          busy,
  output logic [aw-1:0] addrb,
  input  logic [dw-1:0] doutb,
  output logic [47:0]   dst_mac,
  output logic [31:0]   dst_ip,
  output logic [15:0]   dst_port
);

  localparam int unsigned    StgW     = 8 * HDR_LEN;
  localparam logic [aw-1:0]  BaseAddr = aw'(HDR_BASE);
  localparam logic [aw-1:0]  AddrOne  = {{(aw-1){1'b0}}, 1'b1};
  localparam logic [3:0]     LastCnt  = 4'(HDR_LEN - 1);

  state_e          state_q, state_d;
  logic [3:0]      count_q, count_d;
  logic [aw-1:0]   addrb_q, addrb_d;
  logic            owner_q, owner_d;
  logic [StgW-1:0] stg_q, stg_d;
  logic [1:0]      ack_q, ack_d;
  logic [47:0]     mac_q, mac_d;
  logic [31:0]     ip_q, ip_d;
  logic [15:0]     port_q, port_d;

  logic [1:0] arb_grant;
  logic       arb_grant_id;
  logic       arb_advance;

  assign arb_advance = (state_q == StIdle);

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .advance  (arb_advance),
    .grant    (arb_grant),
    .grant_id (arb_grant_id)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addrb_d = addrb_q;
    owner_d = owner_q;
    stg_d   = stg_q;
    ack_d   = 2'b00;
    mac_d   = mac_q;
    ip_d    = ip_q;
    port_d  = port_q;

    unique case (state_q)
      StIdle: begin
        if (arb_grant != 2'b00) begin
          owner_d = arb_grant_id;
          addrb_d = BaseAddr;
          count_d = 4'd0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        // RAM data lags the address by a cycle, so byte k-1 arrives in cycle k.
        if (count_q != 4'd0) begin
          stg_d = {stg_q[StgW-dw-1:0], doutb};
        end
        if (count_q == LastCnt) begin
          state_d = StDrain;
        end else begin
          count_d = count_q + 4'd1;
          addrb_d = addrb_q + AddrOne;
        end
      end
      StDrain: begin
        stg_d   = {stg_q[StgW-dw-1:0], doutb};
        state_d = StDone;
      end
      StDone: begin
        mac_d         = stg_q[StgW-1-8*MAC_OFS  -: 48];
        ip_d          = stg_q[StgW-1-8*IP_OFS   -: 32];
        port_d        = stg_q[StgW-1-8*PORT_OFS -: 16];
        ack_d[owner_q] = 1'b1;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= 4'd0;
      addrb_q <= '0;
      owner_q <= 1'b0;
      stg_q   <= '0;
      ack_q   <= 2'b00;
      mac_q   <= '0;
      ip_q    <= '0;
      port_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addrb_q <= addrb_d;
      owner_q <= owner_d;
      stg_q   <= stg_d;
      ack_q   <= ack_d;
      mac_q   <= mac_d;
      ip_q    <= ip_d;
      port_q  <= port_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign ack      = ack_q;
  assign addrb    = addrb_q;
  assign dst_mac  = mac_q;
  assign dst_ip   = ip_q;
  assign dst_port = port_q;

endmodule

// File: tb/tb_pkheader_fetch.sv
// Directed bench for pkheader_fetch: one default-base instance and one with
// the header placed across the top of a 32-byte RAM.
module tb_pkheader_fetch;

  logic        clk;
  logic        rst;
  logic [1:0]  req, req_w;
  logic [1:0]  ack, ack_w;
  logic        busy, busy_w;
  logic [4:0]  addrb, addrb_w;
  logic [4:0]  addr_r, addr_r_w;
  logic [7:0]  doutb, doutb_w;
  logic [47:0] dst_mac, dst_mac_w;
  logic [31:0] dst_ip, dst_ip_w;
  logic [15:0] dst_port, dst_port_w;
  logic [7:0]  mem [32];

  int nvec;
  int nerr;

  pkheader_fetch #(.aw(5), .dw(8), .HDR_BASE(0)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .ack      (ack),
    .busy     (busy),
    .addrb    (addrb),
    .doutb    (doutb),
    .dst_mac  (dst_mac),
    .dst_ip   (dst_ip),
    .dst_port (dst_port)
  );

  pkheader_fetch #(.aw(5), .dw(8), .HDR_BASE(28)) u_wrap (
    .clk      (clk),
    .rst      (rst),
    .req      (req_w),
    .ack      (ack_w),
    .busy     (busy_w),
    .addrb    (addrb_w),
    .doutb    (doutb_w),
    .dst_mac  (dst_mac_w),
    .dst_ip   (dst_ip_w),
    .dst_port (dst_port_w)
  );

  // Synchronous-read RAM: address registered, data valid the following cycle.
  always_ff @(posedge clk) begin
    addr_r   <= addrb;
    addr_r_w <= addrb_w;
  end
  assign doutb   = mem[addr_r];
  assign doutb_w = mem[addr_r_w];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_hdr(input int base, input logic [95:0] hdr);
    for (int k = 0; k < 32; k++) mem[k] = 8'h00;
    for (int k = 0; k < 12; k++) mem[(base + k) % 32] = hdr[95-8*k -: 8];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 2'b00;
    req_w = 2'b00;
    repeat (2) step();
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
    nvec++; if (ack !== 2'b00) begin nerr++; $display("FAIL reset_ack got %b want 00", ack); end
    nvec++; if (addrb !== 5'd0) begin nerr++; $display("FAIL reset_addrb got %0d want 0", addrb); end
    nvec++;
    if ({dst_mac, dst_ip, dst_port} !== 96'd0) begin
      nerr++; $display("FAIL reset_fields got %h want 0", {dst_mac, dst_ip, dst_port});
    end
    rst = 1'b0;
    repeat (2) step();
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    load_hdr(0, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_80F0);
    req = 2'b01;
    step();
    for (int n = 0; n < 14; n++) begin
      nvec++;
      if (busy !== 1'b1 || ack !== 2'b00) begin
        nerr++; $display("FAIL single_cyc%0d got busy=%b ack=%b want busy=1 ack=00", n, busy, ack);
      end
      if (n < 12) begin
        nvec++;
        if (addrb !== 5'(n)) begin
          nerr++; $display("FAIL single_addr%0d got %0d want %0d", n, addrb, n);
        end
      end
      step();
    end
    nvec++; if (ack !== 2'b01) begin nerr++; $display("FAIL single_ack got %b want 01", ack); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL single_busy_end got %b want 0", busy); end
    nvec++;
    if (dst_mac !== 48'hFFFF_FFFF_FFFF || dst_ip !== 32'hFFFF_FFFF || dst_port !== 16'h80F0) begin
      nerr++; $display("FAIL single_fields got %h %h %h want ffffffffffff ffffffff 80f0",
                       dst_mac, dst_ip, dst_port);
    end
    req = 2'b00;
    step();
    nvec++; if (ack !== 2'b00) begin nerr++; $display("FAIL single_ack_pulse got %b want 00", ack); end
  endtask

  task automatic test_custom();
    load_hdr(0, 96'h0019_24AA_BBCC_C0A8_010A_1388);
    req = 2'b10;
    step();
    for (int n = 0; n < 14; n++) begin
      nvec++;
      if (ack !== 2'b00) begin nerr++; $display("FAIL custom_early%0d got %b want 00", n, ack); end
      nvec++;
      if (dst_port !== 16'h80F0) begin
        nerr++; $display("FAIL custom_partial%0d got %h want 80f0", n, dst_port);
      end
      step();
    end
    nvec++; if (ack !== 2'b10) begin nerr++; $display("FAIL custom_ack got %b want 10", ack); end
    nvec++;
    if (dst_mac !== 48'h0019_24AA_BBCC || dst_ip !== 32'hC0A8_010A || dst_port !== 16'h1388) begin
      nerr++; $display("FAIL custom_fields got %h %h %h want 001924aabbcc c0a8010a 1388",
                       dst_mac, dst_ip, dst_port);
    end
    req = 2'b00;
    step();
  endtask

  task automatic test_drop();
    load_hdr(0, 96'h0102_0304_0506_0708_090A_0B0C);
    req = 2'b10;
    step();
    repeat (3) step();
    req = 2'b00;
    for (int n = 3; n < 14; n++) begin
      nvec++;
      if (busy !== 1'b1 || ack !== 2'b00) begin
        nerr++; $display("FAIL drop_cyc%0d got busy=%b ack=%b want busy=1 ack=00", n, busy, ack);
      end
      step();
    end
    nvec++; if (ack !== 2'b10) begin nerr++; $display("FAIL drop_ack got %b want 10", ack); end
    nvec++;
    if (dst_mac !== 48'h0102_0304_0506 || dst_ip !== 32'h0708_090A || dst_port !== 16'h0B0C) begin
      nerr++; $display("FAIL drop_fields got %h %h %h want 010203040506 0708090a 0b0c",
                       dst_mac, dst_ip, dst_port);
    end
    step();
  endtask

  task automatic test_contention();
    int          ev_cyc [$];
    logic [1:0]  ev_ack [$];
    int          exp_cyc [4] = '{15, 30, 45, 60};
    logic [1:0]  exp_ack [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    load_hdr(0, 96'h0019_24AA_BBCC_C0A8_010A_1388);
    rst = 1'b1;
    req = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 62; c++) begin
      step();
      nvec++;
      if (ack === 2'b11) begin nerr++; $display("FAIL contend_both c%0d got %b want one-hot", c, ack); end
      if (ack !== 2'b00) begin
        ev_cyc.push_back(c);
        ev_ack.push_back(ack);
      end
    end
    nvec++;
    if (ev_cyc.size() != 4) begin
      nerr++; $display("FAIL contend_count got %0d want 4", ev_cyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        nvec++;
        if (ev_cyc[i] != exp_cyc[i] || ev_ack[i] !== exp_ack[i]) begin
          nerr++; $display("FAIL contend_ack%0d got cyc=%0d ack=%b want cyc=%0d ack=%b",
                           i, ev_cyc[i], ev_ack[i], exp_cyc[i], exp_ack[i]);
        end
      end
    end
    req = 2'b00;
    repeat (14) step();
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL contend_drain got %b want 0", busy); end
    nvec++;
    if (dst_mac !== 48'h0019_24AA_BBCC) begin
      nerr++; $display("FAIL contend_mac got %h want 001924aabbcc", dst_mac);
    end
  endtask

  task automatic test_abort();
    req = 2'b01;
    step();
    repeat (6) step();
    rst = 1'b1;
    #1;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL abort_busy got %b want 0", busy); end
    nvec++; if (addrb !== 5'd0) begin nerr++; $display("FAIL abort_addrb got %0d want 0", addrb); end
    nvec++;
    if ({dst_mac, dst_ip, dst_port} !== 96'd0) begin
      nerr++; $display("FAIL abort_fields got %h want 0", {dst_mac, dst_ip, dst_port});
    end
    req = 2'b00;
    repeat (2) step();
    rst = 1'b0;
    for (int n = 0; n < 16; n++) begin
      step();
      nvec++;
      if (ack !== 2'b00 || busy !== 1'b0) begin
        nerr++; $display("FAIL abort_quiet%0d got ack=%b busy=%b want 00 0", n, ack, busy);
      end
    end
    req = 2'b01;
    step();
    for (int n = 0; n < 14; n++) begin
      nvec++;
      if (ack !== 2'b00) begin nerr++; $display("FAIL abort_early%0d got %b want 00", n, ack); end
      step();
    end
    nvec++; if (ack !== 2'b01) begin nerr++; $display("FAIL abort_next_ack got %b want 01", ack); end
    nvec++;
    if (dst_ip !== 32'hC0A8_010A) begin
      nerr++; $display("FAIL abort_next_ip got %h want c0a8010a", dst_ip);
    end
    req = 2'b00;
    step();
  endtask

  task automatic test_wrap();
    load_hdr(28, 96'hA0A1_A2A3_A4A5_A6A7_A8A9_AAAB);
    req_w = 2'b01;
    step();
    for (int n = 0; n < 14; n++) begin
      if (n < 12) begin
        nvec++;
        if (addrb_w !== 5'((28 + n) % 32)) begin
          nerr++; $display("FAIL wrap_addr%0d got %0d want %0d", n, addrb_w, (28 + n) % 32);
        end
      end
      nvec++;
      if (busy_w !== 1'b1) begin nerr++; $display("FAIL wrap_busy%0d got %b want 1", n, busy_w); end
      step();
    end
    nvec++; if (ack_w !== 2'b01) begin nerr++; $display("FAIL wrap_ack got %b want 01", ack_w); end
    nvec++;
    if (dst_mac_w !== 48'hA0A1_A2A3_A4A5 || dst_ip_w !== 32'hA6A7_A8A9 ||
        dst_port_w !== 16'hAAAB) begin
      nerr++; $display("FAIL wrap_fields got %h %h %h want a0a1a2a3a4a5 a6a7a8a9 aaab",
                       dst_mac_w, dst_ip_w, dst_port_w);
    end
    req_w = 2'b00;
    step();
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    for (int k = 0; k < 32; k++) mem[k] = 8'h00;
    test_reset();
    test_single();
    test_custom();
    test_drop();
    test_contention();
    test_abort();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
